// File: rtl/sram_port_arbiter.sv
// Two-port arbiter in front of the single-port 1024x32 SRAM macro: fixed priority
// to port A, with a bounded number of consecutive A wins while B is waiting.
module sram_port_arbiter #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic [DATA_W-1:0] a_bm,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic [DATA_W-1:0] b_bm,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  output logic [DATA_W-1:0] sram_bm,
  output logic              sram_men,
  output logic              sram_wen,
  output logic              sram_ren,
  input  logic [DATA_W-1:0] sram_dout,
  output logic              starve_evt
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_t;

  owner_t            r_rd_owner;
  logic [7:0]        r_hold_cnt;
  logic [DATA_W-1:0] r_a_rdata;
  logic [DATA_W-1:0] r_b_rdata;

  logic w_hold_full;
  logic w_a_gnt;
  logic w_b_gnt;
  logic w_starve;

  assign w_hold_full = (r_hold_cnt == 8'(MAX_HOLD));

  // Grants are gated by rst_n so nothing reaches the macro while in reset.
  always_comb begin
    w_starve = rst_n & a_req & b_req & w_hold_full;
    w_a_gnt  = rst_n & a_req & ~w_starve;
    w_b_gnt  = rst_n & b_req & (~a_req | w_starve);
  end

  always_comb begin
    sram_addr = '0;
    sram_din  = '0;
    sram_bm   = '0;
    sram_men  = 1'b0;
    sram_wen  = 1'b0;
    sram_ren  = 1'b0;
    if (w_a_gnt) begin
      sram_addr = a_addr;
      sram_din  = a_wdata;
      sram_bm   = a_bm;
      sram_men  = 1'b1;
      sram_wen  = a_we;
      sram_ren  = ~a_we;
    end else if (w_b_gnt) begin
      sram_addr = b_addr;
      sram_din  = b_wdata;
      sram_bm   = b_bm;
      sram_men  = 1'b1;
      sram_wen  = b_we;
      sram_ren  = ~b_we;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold_cnt <= '0;
      r_rd_owner <= OWN_NONE;
      r_a_rdata  <= '0;
      r_b_rdata  <= '0;
    end else begin
      if (!b_req || w_b_gnt) begin
        r_hold_cnt <= '0;
      end else if (w_a_gnt && !w_hold_full) begin
        r_hold_cnt <= r_hold_cnt + 8'd1;
      end

      if (w_a_gnt && !a_we) begin
        r_rd_owner <= OWN_A;
      end else if (w_b_gnt && !b_we) begin
        r_rd_owner <= OWN_B;
      end else begin
        r_rd_owner <= OWN_NONE;
      end

      // Capture the delivered word so rdata stays stable between reads.
      if (r_rd_owner == OWN_A) r_a_rdata <= sram_dout;
      if (r_rd_owner == OWN_B) r_b_rdata <= sram_dout;
    end
  end

  assign a_gnt      = w_a_gnt;
  assign b_gnt      = w_b_gnt;
  assign starve_evt = w_starve;
  assign a_rvalid   = (r_rd_owner == OWN_A);
  assign b_rvalid   = (r_rd_owner == OWN_B);
  assign a_rdata    = a_rvalid ? sram_dout : r_a_rdata;
  assign b_rdata    = b_rvalid ? sram_dout : r_b_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: behavioural SRAM, a per-cycle scoreboard model,
// and directed sequences with literal expectations.
module tb_sram_port_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned MH = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, a_bm, b_wdata, b_bm;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din, sram_bm;
  logic          sram_men, sram_wen, sram_ren, starve_evt;
  logic [DW-1:0] sram_dout = '0;

  logic          x_a_gnt, x_a_rvalid, x_b_gnt, x_b_rvalid;
  logic [DW-1:0] x_a_rdata, x_b_rdata, x_din, x_bm;
  logic [AW-1:0] x_addr;
  logic          x_men, x_wen, x_ren, x_starve;

  int n_checks = 0;
  int n_fail   = 0;
  bit en       = 1'b0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_bm(a_bm),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_bm(b_bm),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_bm(sram_bm),
    .sram_men(sram_men), .sram_wen(sram_wen), .sram_ren(sram_ren),
    .sram_dout(sram_dout), .starve_evt(starve_evt)
  );

  // Second instance with MAX_HOLD=1; only its grants are examined.
  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(1)) u_alt (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_bm(a_bm),
    .a_gnt(x_a_gnt), .a_rvalid(x_a_rvalid), .a_rdata(x_a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_bm(b_bm),
    .b_gnt(x_b_gnt), .b_rvalid(x_b_rvalid), .b_rdata(x_b_rdata),
    .sram_addr(x_addr), .sram_din(x_din), .sram_bm(x_bm),
    .sram_men(x_men), .sram_wen(x_wen), .sram_ren(x_ren),
    .sram_dout(sram_dout), .starve_evt(x_starve)
  );

  logic [DW-1:0] mem [0:1023] = '{default: '0};
  always @(posedge clk) begin
    if (sram_men && sram_wen) mem[sram_addr] <= (mem[sram_addr] & ~sram_bm) | (sram_din & sram_bm);
    if (sram_men && sram_ren) sram_dout <= mem[sram_addr];
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endfunction

  // Scoreboard: who should win this cycle, and what each port should see.
  logic [DW-1:0] shadow [0:1023] = '{default: '0};
  int            m_wait = 0;
  bit            m_pend_a = 0, m_pend_b = 0;
  logic [DW-1:0] m_data_a = '0, m_data_b = '0, m_last_a = '0, m_last_b = '0;

  always @(negedge clk) begin
    logic e_st, e_ag, e_bg;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din, e_bm;
    logic e_men, e_wen, e_ren;
    if (en) begin
      e_st = rst_n && a_req && b_req && (m_wait >= int'(MH));
      e_ag = rst_n && a_req && !e_st;
      e_bg = rst_n && b_req && (!a_req || e_st);
      e_addr = '0; e_din = '0; e_bm = '0; e_men = 0; e_wen = 0; e_ren = 0;
      if (e_ag) begin
        e_addr = a_addr; e_din = a_wdata; e_bm = a_bm; e_men = 1; e_wen = a_we; e_ren = !a_we;
      end else if (e_bg) begin
        e_addr = b_addr; e_din = b_wdata; e_bm = b_bm; e_men = 1; e_wen = b_we; e_ren = !b_we;
      end
      chk("a_gnt", a_gnt, e_ag);
      chk("b_gnt", b_gnt, e_bg);
      chk("starve_evt", starve_evt, e_st);
      chk("sram_men", sram_men, e_men);
      chk("sram_wen", sram_wen, e_wen);
      chk("sram_ren", sram_ren, e_ren);
      chk("sram_addr", 32'(sram_addr), 32'(e_addr));
      chk("sram_din", sram_din, e_din);
      chk("sram_bm", sram_bm, e_bm);
      chk("a_rvalid", a_rvalid, m_pend_a);
      chk("b_rvalid", b_rvalid, m_pend_b);
      chk("a_rdata", a_rdata, m_pend_a ? m_data_a : m_last_a);
      chk("b_rdata", b_rdata, m_pend_b ? m_data_b : m_last_b);

      if (m_pend_a) m_last_a <= m_data_a;
      if (m_pend_b) m_last_b <= m_data_b;
      m_pend_a <= e_ag && !a_we;
      m_pend_b <= e_bg && !b_we;
      m_data_a <= shadow[a_addr];
      m_data_b <= shadow[b_addr];
      if (e_ag && a_we) shadow[a_addr] <= (shadow[a_addr] & ~a_bm) | (a_wdata & a_bm);
      if (e_bg && b_we) shadow[b_addr] <= (shadow[b_addr] & ~b_bm) | (b_wdata & b_bm);
      if (!b_req || e_bg) m_wait <= 0;
      else if (e_ag)      m_wait <= (m_wait + 1 > int'(MH)) ? int'(MH) : m_wait + 1;
      if (!rst_n) begin
        m_wait <= 0; m_pend_a <= 0; m_pend_b <= 0; m_last_a <= '0; m_last_b <= '0;
      end
    end
  end

  task automatic a_xfer(input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wd, input logic [DW-1:0] bm);
    bit got = 0;
    a_req = 1; a_we = we; a_addr = ad; a_wdata = wd; a_bm = bm;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_gnt === 1'b1) begin got = 1; break; end
    end
    chk("a_grant_wait", 32'(got), 1);
    @(posedge clk); #1; a_req = 0;
  endtask

  task automatic b_xfer(input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wd, input logic [DW-1:0] bm);
    bit got = 0;
    b_req = 1; b_we = we; b_addr = ad; b_wdata = wd; b_bm = bm;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b_gnt === 1'b1) begin got = 1; break; end
    end
    chk("b_grant_wait", 32'(got), 1);
    @(posedge clk); #1; b_req = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0; a_req = 1; b_req = 1; a_we = 0; b_we = 0;
    a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0; a_bm = '0; b_bm = '0;
    repeat (2) @(posedge clk);
    #1; en = 1;
    @(negedge clk);
    chk("rst_a_gnt", a_gnt, 0); chk("rst_b_gnt", b_gnt, 0);
    chk("rst_men", sram_men, 0); chk("rst_a_rvalid", a_rvalid, 0); chk("rst_b_rvalid", b_rvalid, 0);
    @(posedge clk); #1; rst_n = 1;
    @(negedge clk);
    chk("post_rst_a_gnt", a_gnt, 1); chk("post_rst_b_gnt", b_gnt, 0);
    @(posedge clk); #1; a_req = 0; b_req = 0;
    @(posedge clk); #1;

    a_xfer(1, 10'h005, 32'h0000_00A5, 32'h0000_00FF);
    a_xfer(0, 10'h005, '0, '0);
    @(negedge clk);
    chk("wr_rd_a_rvalid", a_rvalid, 1); chk("wr_rd_a_rdata", a_rdata, 32'h0000_00A5);
    chk("wr_rd_b_rvalid", b_rvalid, 0);
    @(posedge clk); #1;

    b_xfer(1, 10'h3FF, 32'h1234_5678, 32'hFFFF_FFFF);
    b_req = 1; b_we = 0; b_addr = 10'h3FF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("b3_gnt", b_gnt, 1);
      if (i > 0) begin
        chk("b3_rvalid", b_rvalid, 1); chk("b3_rdata", b_rdata, 32'h1234_5678);
      end
      @(posedge clk); #1;
    end
    b_req = 0;
    @(negedge clk);
    chk("b3_last_rvalid", b_rvalid, 1); chk("b3_last_rdata", b_rdata, 32'h1234_5678);
    chk("b3_a_rvalid", a_rvalid, 0);
    @(posedge clk); #1;

    a_xfer(1, 10'h010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    a_xfer(1, 10'h010, 32'h0000_0000, 32'h0000_FF00);
    a_xfer(0, 10'h010, '0, '0);
    @(negedge clk);
    chk("mask_rvalid", a_rvalid, 1); chk("mask_rdata", a_rdata, 32'hFFFF_00FF);
    @(posedge clk); #1;

    a_req = 1; a_we = 0; a_addr = 10'h001; b_req = 1; b_we = 0; b_addr = 10'h002;
    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      chk("starve_b_gnt", b_gnt, (i % 9) == 8);
      chk("starve_a_gnt", a_gnt, (i % 9) != 8);
      chk("starve_pulse", starve_evt, (i % 9) == 8);
      chk("alt_a_gnt", x_a_gnt, (i % 2) == 0);
      chk("alt_b_gnt", x_b_gnt, (i % 2) == 1);
      @(posedge clk); #1;
    end
    a_req = 0; b_req = 0;
    @(posedge clk); #1;

    a_req = 1; a_we = 0; a_addr = 10'h005;
    @(negedge clk);
    chk("mid_rd_gnt", a_gnt, 1);
    @(posedge clk); #1; rst_n = 0; b_req = 1;
    @(negedge clk);
    chk("mid_rd_rvalid", a_rvalid, 1); chk("mid_rd_rdata", a_rdata, 32'h0000_00A5);
    chk("mid_rst_gnt", a_gnt | b_gnt, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_rvalid", a_rvalid, 0); chk("mid_rst_rdata", a_rdata, 0);
    @(posedge clk); #1; rst_n = 1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("rel_a_gnt", a_gnt, i < 8); chk("rel_b_gnt", b_gnt, i == 8);
      @(posedge clk); #1;
    end
    a_req = 0; b_req = 0;
    repeat (3) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
